normalize: RTL



---
 rtl/normalize_pkg.sv | 36 +++
 rtl/normalize_step.sv | 42 ++++
 rtl/normalize.sv | 96 +++++++++
 3 files changed

// File: rtl/normalize_pkg.sv
// Shared types and constants for the multi-cycle left-normalizer.
package normalize_pkg;

  localparam int MANT_W    = 64;
  localparam int EXP_W     = 7;
  localparam int CNT_W     = 7;
  localparam int NORM_STEP = 8;

  localparam logic [CNT_W-1:0] NORM_ZERO_COUNT = 7'd127;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

  typedef enum logic [2:0] {
    STEP_COARSE,
    STEP_FINE,
    STEP_FINAL,
    STEP_ZERO,
    STEP_UNFL
  } norm_step_kind_t;

  typedef struct packed {
    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  exp;
    logic [CNT_W-1:0]  count;
  } norm_op_t;

  // A terminal step ends the SHIFT phase and produces the result.
  function automatic logic is_terminal(input norm_step_kind_t kind);
    return (kind == STEP_FINAL) || (kind == STEP_ZERO) || (kind == STEP_UNFL);
  endfunction

endpackage

// File: rtl/normalize_step.sv
// Combinational single step of the normalizer; NORM_BYTE_STEP_EN adds the 8-bit coarse step.
module norm_step
  import normalize_pkg::*;
(
  input  norm_op_t        cur,
  output norm_op_t        nxt,
  output norm_step_kind_t kind
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    nxt  = cur;
    kind = STEP_FINAL;

    if (cur.mant == '0) begin
      kind      = STEP_ZERO;
      nxt.exp   = '0;
      nxt.count = NORM_ZERO_COUNT;
    end else if (cur.mant[MANT_W-1]) begin
      kind = STEP_FINAL;
`ifdef NORM_BYTE_STEP_EN
    end else if ((cur.mant[MANT_W-1 -: NORM_STEP] == '0) &&
                 (cur.exp >= EXP_W'(NORM_STEP))) begin
      kind      = STEP_COARSE;
      nxt.mant  = cur.mant << NORM_STEP;
      nxt.exp   = cur.exp - EXP_W'(NORM_STEP);
      nxt.count = cur.count + CNT_W'(NORM_STEP);
`endif
    end else if (cur.exp != '0) begin
      kind      = STEP_FINE;
      nxt.mant  = cur.mant << 1;
      nxt.exp   = cur.exp - EXP_W'(1);
      nxt.count = cur.count + CNT_W'(1);
    end else begin
      // Exponent exhausted before bit 63 was reached: flush, keep the shifts done so far.
      kind     = STEP_UNFL;
      nxt.mant = '0;
      nxt.exp  = '0;
    end
  end

endmodule

// File: rtl/normalize.sv
// Multi-cycle left-normalizer with valid/ready handshakes on both sides.
// Optional macro NORM_BYTE_STEP_EN enables 8-bit coarse steps (latency only).
module normalize
  import normalize_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_zero,
  output logic              out_unfl
);

  norm_state_t     state_q, state_d;
  norm_op_t        work_q, work_d;
  norm_op_t        res_q, res_d;
  logic            zero_q, zero_d;
  logic            unfl_q, unfl_d;
  norm_op_t        step_nxt;
  norm_step_kind_t step_kind;

  norm_step u_step (
    .cur  (work_q),
    .nxt  (step_nxt),
    .kind (step_kind)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unfl_d  = unfl_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = '{mant: in_mant, exp: in_exp, count: '0};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = step_nxt;
        // The result register is only written at the end, so no partial value is ever shown.
        if (is_terminal(step_kind)) begin
          res_d   = step_nxt;
          zero_d  = (step_kind == STEP_ZERO);
          unfl_d  = (step_kind == STEP_UNFL);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          zero_d  = 1'b0;
          unfl_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the state so outputs read 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      unfl_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      unfl_q  <= unfl_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_mant  = res_q.mant;
  assign out_exp   = res_q.exp;
  assign out_count = res_q.count;
  assign out_zero  = zero_q;
  assign out_unfl  = unfl_q;

endmodule
